// File: rtl/cmat4_stream_loader_if.sv
// cmat4_stream_loader_if: element stream in, parallel A/B matrix pair out, framing status.
interface cmat4_stream_loader_if #(parameter int w = 32);
    logic                in_valid, in_ready, in_last;
    logic signed [w-1:0] in_real, in_imag;
    logic signed [w-1:0] A_real [0:3][0:3];
    logic signed [w-1:0] A_imag [0:3][0:3];
    logic signed [w-1:0] B_real [0:3][0:3];
    logic signed [w-1:0] B_imag [0:3][0:3];
    logic                mat_valid, mat_ready;
    logic                frame_err, frame_err_clr;
    modport slave (
        input  in_valid, in_real, in_imag, in_last, mat_ready, frame_err_clr,
        output in_ready, A_real, A_imag, B_real, B_imag, mat_valid, frame_err
    );
    modport master (
        output in_valid, in_real, in_imag, in_last, mat_ready, frame_err_clr,
        input  in_ready, A_real, A_imag, B_real, B_imag, mat_valid, frame_err
    );
endinterface

// File: rtl/cmat4_stream_loader.sv
// cmat4_stream_loader: assembles 32-beat frames into A/B matrices with framing checks.
// Define CMAT4_LOADER_DOUBLE_BUFFER_EN for two ping-pong banks; otherwise one bank.
module cmat4_stream_loader #(parameter int w = 32) (
    input logic clk,
    input logic rst,
    cmat4_stream_loader_if.slave bus
);
    typedef enum logic {FILL, RESYNC} state_t;
    state_t              state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [1:0]          full_q, full_d;
    logic                wr_q, wr_d, rd_q, rd_d, err_q, err_d, run_q;
    logic                acc, rel, we;
    logic signed [w-1:0] re_q [0:1][0:31];
    logic signed [w-1:0] im_q [0:1][0:31];

    function automatic logic nxt(input logic b);
`ifdef CMAT4_LOADER_DOUBLE_BUFFER_EN
        return ~b;
`else
        return b;
`endif
    endfunction

    // run_q keeps in_ready low through reset without looking at rst combinationally
    assign bus.in_ready  = run_q & (state_q == RESYNC | ~full_q[wr_q]);
    assign bus.mat_valid = full_q[rd_q];
    assign bus.frame_err = err_q;
    assign acc = bus.in_valid & bus.in_ready;
    assign rel = bus.mat_valid & bus.mat_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        full_d  = full_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        err_d   = err_q & ~bus.frame_err_clr;
        we      = 1'b0;
        if (rel) begin
            full_d[rd_q] = 1'b0;
            rd_d         = nxt(rd_q);
        end
        if (acc) begin
            if (state_q == RESYNC) begin
                if (bus.in_last) begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
            end else begin
                we    = 1'b1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    if (bus.in_last) begin
                        full_d[wr_q] = 1'b1;
                        wr_d         = nxt(wr_q);
                    end else begin
                        err_d   = 1'b1;
                        state_d = RESYNC;
                    end
                end else if (bus.in_last) begin
                    err_d = 1'b1;
                    cnt_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            full_q  <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            run_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++)
                for (int k = 0; k < 32; k++) begin
                    re_q[b][k] <= '0;
                    im_q[b][k] <= '0;
                end
        end else if (we) begin
            re_q[wr_q][cnt_q] <= bus.in_real;
            im_q[wr_q][cnt_q] <= bus.in_imag;
        end
    end

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign bus.A_real[r][c] = re_q[rd_q][4*r+c];
            assign bus.A_imag[r][c] = im_q[rd_q][4*r+c];
            assign bus.B_real[r][c] = re_q[rd_q][16+4*r+c];
            assign bus.B_imag[r][c] = im_q[rd_q][16+4*r+c];
        end
    end
endmodule
